// File: rtl/sdram_a_ref.sv
// rtl/sdram_a_ref.sv - SDRAM auto-refresh sequencer: interval timer, arbiter request, PRECHARGE + AUTO_REFRESH burst
module sdram_a_ref #(
    parameter int CNT_REF_MAX = 750,
    parameter int TRP_CLK     = 2,
    parameter int TRFC_CLK    = 7,
    parameter int AREF_TIMES  = 2
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        init_end,
    input  logic        aref_en,
    output logic        aref_req,
    output logic [3:0]  aref_cmd,
    output logic [1:0]  aref_ba,
    output logic [12:0] aref_addr,
    output logic        aref_end
);

    localparam int REF_W   = $clog2(CNT_REF_MAX);
    localparam int CLK_MAX = (TRFC_CLK > TRP_CLK) ? TRFC_CLK : TRP_CLK;
    localparam int CLK_W   = $clog2(CLK_MAX) + 1;
    localparam int AR_W    = $clog2(AREF_TIMES + 1);

    localparam logic [REF_W-1:0] REF_LAST  = REF_W'(CNT_REF_MAX - 1);
    localparam logic [CLK_W-1:0] TRP_LAST  = CLK_W'(TRP_CLK - 1);
    localparam logic [CLK_W-1:0] TRFC_LAST = CLK_W'(TRFC_CLK - 1);
    localparam logic [AR_W-1:0]  AR_TOTAL  = AR_W'(AREF_TIMES);

    // {cs#, ras#, cas#, we#}
    localparam logic [3:0]  CMD_NOP  = 4'b0111;
    localparam logic [3:0]  CMD_PCHA = 4'b0010;
    localparam logic [3:0]  CMD_AREF = 4'b0001;
    localparam logic [1:0]  BA_IDLE  = 2'b11;
    localparam logic [12:0] ADDR_ALL = 13'h1fff;   // A10=1 selects all banks on PRECHARGE

    typedef enum logic [2:0] {
        AREF_IDLE = 3'd0,
        AREF_PCHA = 3'd1,
        AREF_TRP  = 3'd2,
        AREF_AR   = 3'd3,
        AREF_TRFC = 3'd4,
        AREF_END  = 3'd5
    } state_t;

    state_t             state_q;
    logic [CLK_W-1:0]   cnt_clk_q;
    logic [AR_W-1:0]    cnt_ar_q;
    logic [REF_W-1:0]   cnt_ref_q, cnt_ref_d;
    logic               aref_req_q, aref_req_d;
    logic [3:0]         aref_cmd_q;
    logic [1:0]         aref_ba_q;
    logic [12:0]        aref_addr_q;
    logic               aref_end_q;
    logic               ref_hit;
    logic               leave_idle;

    assign ref_hit    = init_end && (cnt_ref_q == REF_LAST);
    assign leave_idle = (state_q == AREF_IDLE) && aref_en && aref_req_q;

    // Free-running refresh interval timer and request flag; a new interval tick beats a grant on the same edge
    always_comb begin
        cnt_ref_d  = cnt_ref_q;
        aref_req_d = aref_req_q;
        if (!init_end) begin
            cnt_ref_d  = '0;
            aref_req_d = 1'b0;
        end else begin
            cnt_ref_d = (cnt_ref_q == REF_LAST) ? '0 : cnt_ref_q + 1'b1;
            if (ref_hit) begin
                aref_req_d = 1'b1;
            end else if (leave_idle) begin
                aref_req_d = 1'b0;
            end
        end
    end

    // Timer and request registers
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt_ref_q  <= '0;
            aref_req_q <= 1'b0;
        end else begin
            cnt_ref_q  <= cnt_ref_d;
            aref_req_q <= aref_req_d;
        end
    end

    // Refresh sequence FSM; pin outputs are registered from the current state and so trail it by one cycle
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= AREF_IDLE;
            cnt_clk_q   <= '0;
            cnt_ar_q    <= '0;
            aref_cmd_q  <= CMD_NOP;
            aref_ba_q   <= BA_IDLE;
            aref_addr_q <= ADDR_ALL;
            aref_end_q  <= 1'b0;
        end else begin
            cnt_clk_q <= '0;
            case (state_q)
                AREF_IDLE: begin
                    cnt_ar_q <= '0;
                    if (aref_en && aref_req_q) begin
                        state_q <= AREF_PCHA;
                    end
                end
                AREF_PCHA: begin
                    state_q <= AREF_TRP;
                end
                AREF_TRP: begin
                    if (cnt_clk_q == TRP_LAST) begin
                        state_q <= AREF_AR;
                    end else begin
                        cnt_clk_q <= cnt_clk_q + 1'b1;
                    end
                end
                AREF_AR: begin
                    cnt_ar_q <= cnt_ar_q + 1'b1;
                    state_q  <= AREF_TRFC;
                end
                AREF_TRFC: begin
                    if (cnt_clk_q == TRFC_LAST) begin
                        state_q <= (cnt_ar_q < AR_TOTAL) ? AREF_AR : AREF_END;
                    end else begin
                        cnt_clk_q <= cnt_clk_q + 1'b1;
                    end
                end
                AREF_END: begin
                    state_q <= AREF_IDLE;
                end
                default: begin
                    state_q  <= AREF_IDLE;
                    cnt_ar_q <= '0;
                end
            endcase

            aref_cmd_q  <= CMD_NOP;
            aref_ba_q   <= BA_IDLE;
            aref_addr_q <= ADDR_ALL;
            aref_end_q  <= 1'b0;
            case (state_q)
                AREF_PCHA: aref_cmd_q <= CMD_PCHA;
                AREF_AR:   aref_cmd_q <= CMD_AREF;
                AREF_END:  aref_end_q <= 1'b1;
                default:   ;
            endcase
        end
    end

    assign aref_req  = aref_req_q;
    assign aref_cmd  = aref_cmd_q;
    assign aref_ba   = aref_ba_q;
    assign aref_addr = aref_addr_q;
    assign aref_end  = aref_end_q;

endmodule

// File: tb/tb_sdram_a_ref.sv
// tb/tb_sdram_a_ref.sv - directed scoreboard bench for the SDRAM auto-refresh sequencer
module tb_sdram_a_ref;

    typedef struct packed {
        logic [3:0]  cmd;
        logic [1:0]  ba;
        logic [12:0] addr;
        logic        fin;
    } exp_t;

    logic        sys_clk;
    logic        sys_rst;
    logic        init_end;
    logic        aref_en;
    logic        aref_req;
    logic [3:0]  aref_cmd;
    logic [1:0]  aref_ba;
    logic [12:0] aref_addr;
    logic        aref_end;

    int   checks;
    int   errors;
    int   n;
    int   ar_cnt;
    exp_t sb[$];

    sdram_a_ref dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .init_end  (init_end),
        .aref_en   (aref_en),
        .aref_req  (aref_req),
        .aref_cmd  (aref_cmd),
        .aref_ba   (aref_ba),
        .aref_addr (aref_addr),
        .aref_end  (aref_end)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    function automatic exp_t mk(input logic [3:0] cmd, input logic fin);
        exp_t e;
        e.cmd  = cmd;
        e.ba   = 2'b11;
        e.addr = 13'h1fff;
        e.fin  = fin;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at step %0d: observed %0h expected %0h", tag, n, obs, exp);
        end
    endtask

    // Expected pin trace from the grant edge onward: grant-cycle NOP, then the 20-cycle sequence
    task automatic push_seq();
        sb.push_back(mk(4'b0111, 1'b0));
        sb.push_back(mk(4'b0010, 1'b0));
        repeat (2) sb.push_back(mk(4'b0111, 1'b0));
        sb.push_back(mk(4'b0001, 1'b0));
        repeat (7) sb.push_back(mk(4'b0111, 1'b0));
        sb.push_back(mk(4'b0001, 1'b0));
        repeat (7) sb.push_back(mk(4'b0111, 1'b0));
        sb.push_back(mk(4'b0111, 1'b1));
    endtask

    task automatic check_pins(input string tag, input logic req_exp, input exp_t e);
        chk({tag, "_req"}, 32'(aref_req), 32'(req_exp));
        chk({tag, "_cmd"}, 32'(aref_cmd), 32'(e.cmd));
        chk({tag, "_ba"}, 32'(aref_ba), 32'(e.ba));
        chk({tag, "_addr"}, 32'(aref_addr), 32'(e.addr));
        chk({tag, "_end"}, 32'(aref_end), 32'(e.fin));
    endtask

    // One clock: sample on the falling edge, compare against the scoreboard head or idle NOP
    task automatic step(input logic req_exp);
        exp_t e;
        @(negedge sys_clk);
        n++;
        if (sb.size() > 0) e = sb.pop_front();
        else               e = mk(4'b0111, 1'b0);
        if (aref_cmd == 4'b0001) ar_cnt++;
        check_pins("step", req_exp, e);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        n        = 0;
        ar_cnt   = 0;
        sys_rst  = 1'b1;
        init_end = 1'b0;
        aref_en  = 1'b0;

        // Reset state
        repeat (3) step(1'b0);
        sys_rst = 1'b0;

        // init_end low for 2000 cycles, with a stray grant pulse in the middle
        for (int i = 0; i < 2000; i++) begin
            step(1'b0);
            if (i == 1000) aref_en = 1'b1;
            if (i == 1001) aref_en = 1'b0;
        end
        chk("no_aref_before_init", 32'(ar_cnt), 32'd0);

        // Timer start: request exactly 750 cycles after init_end rises, then held
        init_end = 1'b1;
        n = 0;
        repeat (749) step(1'b0);
        step(1'b1);
        repeat (299) step(1'b1);

        // Grant 300 cycles late
        aref_en = 1'b1;
        push_seq();
        repeat (450) step(1'b0);
        chk("late_grant_sb_drained", 32'(sb.size()), 32'd0);

        // Grant tied high: request still on the 750-cycle grid, drops one cycle later
        ar_cnt = 0;
        step(1'b1);
        push_seq();
        repeat (749) step(1'b0);
        chk("two_aref_per_period", 32'(ar_cnt), 32'd2);
        step(1'b1);
        push_seq();
        repeat (49) step(1'b0);
        aref_en = 1'b0;
        repeat (100) step(1'b0);

        // Grant pulse with no request pending is ignored
        aref_en = 1'b1;
        step(1'b0);
        aref_en = 1'b0;
        repeat (599) step(1'b0);
        step(1'b1);

        // Reset during the first tRFC wait
        aref_en = 1'b1;
        push_seq();
        repeat (5) step(1'b0);
        ar_cnt  = 0;
        sys_rst = 1'b1;
        aref_en = 1'b0;
        #1;
        check_pins("async_rst", 1'b0, mk(4'b0111, 1'b0));
        sb.delete();
        repeat (5) step(1'b0);
        sys_rst = 1'b0;
        n = 0;
        repeat (749) step(1'b0);
        step(1'b1);
        repeat (10) step(1'b1);
        chk("no_aref_after_rst", 32'(ar_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
